// File: rtl/viterbi_pkg.sv
// Shared types and default sizes for the Viterbi survivor-path blocks.
package viterbi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } surv_state_t;

    localparam int SURV_DEPTH_DEF = 1024;
    localparam int SURV_WIDTH_DEF = 8;

endpackage

// File: rtl/surv_ram_dp.sv
// Simple dual-port RAM: one write port, one registered read port, read-first on
// a same-address collision. Contents are not reset; only the read register is.
module surv_ram_dp #(
    parameter int DW    = 8,
    parameter int DEPTH = 1024,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Non-blocking update of mem_q means a colliding read still sees the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/surv_path_mem.sv
// Circular survivor-path memory: pushes one decision word per trellis step and
// streams the newest words back newest-first. Optional parity: SURV_MEM_PARITY_EN.
module surv_path_mem
    import viterbi_pkg::*;
#(
    parameter int WIDTH = SURV_WIDTH_DEF,
    parameter int DEPTH = SURV_DEPTH_DEF,
    parameter int LEN_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             tb_start,
    input  logic [LEN_W-1:0] tb_len,
    output logic             tb_busy,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_last,
    output logic             rd_par_err,
    output logic [LEN_W-1:0] fill_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef SURV_MEM_PARITY_EN
    localparam int RAM_W = WIDTH + 1;
`else
    localparam int RAM_W = WIDTH;
`endif
    localparam logic [AW-1:0]    LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [LEN_W-1:0] FULL_CNT  = LEN_W'(DEPTH);
    localparam logic [LEN_W-1:0] ONE_LEN   = LEN_W'(1);

    surv_state_t      state_q;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    newest_addr;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] eff_len;
    logic             rd_valid_q;
    logic             rd_last_q;
    logic             rd_issue;
    logic [RAM_W-1:0] ram_wdata;
    logic [RAM_W-1:0] ram_rdata;

    // Explicit wrap so DEPTH need not be a power of two.
    always_comb begin
        wr_ptr_d    = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + AW'(1);
        newest_addr = (wr_ptr_q == '0) ? LAST_ADDR : wr_ptr_q - AW'(1);
        rd_ptr_d    = (rd_ptr_q == '0) ? LAST_ADDR : rd_ptr_q - AW'(1);
        fill_d      = (fill_q == FULL_CNT) ? fill_q : fill_q + ONE_LEN;
        eff_len     = (tb_len < fill_q) ? tb_len : fill_q;
    end

    assign rd_issue = (state_q == READ);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            state_q    <= IDLE;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_d;
                fill_q   <= fill_d;
            end
            rd_valid_q <= rd_issue;
            rd_last_q  <= rd_issue && (cnt_q == ONE_LEN);
            case (state_q)
                IDLE: begin
                    // fill_q is the pre-write value, so a same-cycle push is excluded.
                    if (tb_start && (eff_len != '0)) begin
                        rd_ptr_q <= newest_addr;
                        cnt_q    <= eff_len;
                        state_q  <= READ;
                    end
                end
                READ: begin
                    rd_ptr_q <= rd_ptr_d;
                    cnt_q    <= cnt_q - ONE_LEN;
                    if (cnt_q == ONE_LEN) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef SURV_MEM_PARITY_EN
    assign ram_wdata  = {^wr_data, wr_data};
    assign rd_par_err = rd_valid_q && ((^ram_rdata[WIDTH-1:0]) != ram_rdata[WIDTH]);
`else
    assign ram_wdata  = wr_data;
    assign rd_par_err = 1'b0;
`endif

    surv_ram_dp #(
        .DW    (RAM_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_en && !rst),
        .waddr_i (wr_ptr_q),
        .wdata_i (ram_wdata),
        .re_i    (rd_issue),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    assign rd_data  = ram_rdata[WIDTH-1:0];
    assign rd_valid = rd_valid_q;
    assign rd_last  = rd_last_q;
    assign tb_busy  = (state_q != IDLE);
    assign fill_cnt = fill_q;

endmodule
